// File: rtl/imem_pkg.sv
// ---------------------------------------------------------------------------
// imem_pkg
// Shared defaults for the synchronous instruction memory. Fetch and decode
// import the same constants so they agree on instruction width, program size
// and the filler word returned for addresses outside the program.
// ---------------------------------------------------------------------------
package imem_pkg;

  localparam int IMEM_DATA_W = 32;
  localparam int IMEM_DEPTH  = 64;
  localparam int IMEM_ADDR_W = 8;

  // Word handed back for out-of-range fetches.
  localparam logic [IMEM_DATA_W-1:0] IMEM_NOP_INST = 32'h0000_0000;

  // Bits needed to index a DEPTH-entry array; never less than 1.
  function automatic int imem_idx_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/imem_skid.sv
// ---------------------------------------------------------------------------
// imem_skid
// Two-entry in-order response buffer sitting behind the registered array
// read. A fresh read result is offered on in_* for exactly one cycle. If the
// buffer is empty it passes straight through so the response still appears
// in the cycle after the request. Otherwise it is queued behind the older
// entries. The instantiating logic never has more than two responses in
// flight, so the buffer cannot overflow.
//
// Ports
//   clk, rst_n            clock, asynchronous active-low reset
//   flush                 discard everything held plus this cycle's input
//   in_valid/in_inst/in_err   fresh read result (one-cycle pulse)
//   out_valid/out_ready   response handshake toward the consumer
//   out_inst/out_err      head response; driven to zero while not valid
// ---------------------------------------------------------------------------
module imem_skid
  import imem_pkg::*;
#(
  parameter int DATA_W = IMEM_DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_inst,
  input  logic              in_err,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_inst,
  output logic              out_err
);

  logic [1:0]        count, count_next;
  logic [DATA_W-1:0] inst0, inst0_next, inst1, inst1_next;
  logic              err0, err0_next, err1, err1_next;
  logic              pop;

  // Head is the oldest stored entry; if nothing is stored, the fresh input
  // is the head. Outputs are zero when idle so reset shows a clean bus.
  always_comb begin
    out_valid = (count != 2'd0) || in_valid;
    out_inst  = '0;
    out_err   = 1'b0;
    if (count != 2'd0) begin
      out_inst = inst0;
      out_err  = err0;
    end else if (in_valid) begin
      out_inst = in_inst;
      out_err  = in_err;
    end
    pop = out_valid && out_ready;
  end

  // Queue update: append the fresh input behind stored entries, then drop
  // the head if the consumer took it this cycle.
  always_comb begin
    count_next = count;
    inst0_next = inst0;
    err0_next  = err0;
    inst1_next = inst1;
    err1_next  = err1;
    case (count)
      2'd0: begin
        if (in_valid && !pop) begin
          inst0_next = in_inst;
          err0_next  = in_err;
          count_next = 2'd1;
        end
      end
      2'd1: begin
        if (in_valid && pop) begin
          inst0_next = in_inst;
          err0_next  = in_err;
        end else if (in_valid) begin
          inst1_next = in_inst;
          err1_next  = in_err;
          count_next = 2'd2;
        end else if (pop) begin
          count_next = 2'd0;
        end
      end
      default: begin
        if (pop) begin
          inst0_next = inst1;
          err0_next  = err1;
          count_next = 2'd1;
        end
      end
    endcase
    if (flush) begin
      count_next = 2'd0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= 2'd0;
      inst0 <= '0;
      err0  <= 1'b0;
      inst1 <= '0;
      err1  <= 1'b0;
    end else begin
      count <= count_next;
      inst0 <= inst0_next;
      err0  <= err0_next;
      inst1 <= inst1_next;
      err1  <= err1_next;
    end
  end

endmodule

// File: rtl/imem_sync.sv
// ---------------------------------------------------------------------------
// imem_sync
// Synchronous instruction memory between PC/fetch and decode. A request
// accepted in one cycle is answered in the next (when nothing is queued).
// Up to two responses may be outstanding, so short fetch-stage stalls do
// not lose data. flush_i drops everything pending on a redirect, and a load
// port lets software download a program at run time.
//
// Ports
//   clk_i, rst_ni                      clock, asynchronous active-low reset
//   req_valid_i/req_ready_o/req_addr_i fetch request handshake + word address
//   rsp_valid_o/rsp_ready_i            response handshake
//   rsp_inst_o, rsp_err_o              instruction word, out-of-range flag
//   flush_i                            drop all pending responses
//   ld_we_i, ld_addr_i, ld_data_i      program download write port
// ---------------------------------------------------------------------------
module imem_sync
  import imem_pkg::*;
#(
  parameter int                DATA_W    = IMEM_DATA_W,
  parameter int                DEPTH     = IMEM_DEPTH,
  parameter int                ADDR_W    = IMEM_ADDR_W,
  parameter string             INIT_FILE = "prog.hex",
  parameter logic [DATA_W-1:0] NOP_INST  = IMEM_NOP_INST
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic [ADDR_W-1:0] req_addr_i,
  output logic              rsp_valid_o,
  input  logic              rsp_ready_i,
  output logic [DATA_W-1:0] rsp_inst_o,
  output logic              rsp_err_o,
  input  logic              flush_i,
  input  logic              ld_we_i,
  input  logic [ADDR_W-1:0] ld_addr_i,
  input  logic [DATA_W-1:0] ld_data_i
);

  localparam int IDX_W = imem_idx_w(DEPTH);
  // One extra bit so DEPTH == 2**ADDR_W is still representable.
  localparam logic [ADDR_W:0] DEPTH_LIM = (ADDR_W + 1)'(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];

  logic              req_in_range, ld_in_range;
  logic              accept, rsp_hs;
  logic [1:0]        occ;
  logic              rd_valid, rd_err;
  logic [DATA_W-1:0] rd_word, rd_inst;

  // Range checks and handshake qualifiers. Ready depends combinationally
  // only on the load and flush inputs; the occupancy term is registered.
  always_comb begin
    req_in_range = {1'b0, req_addr_i} < DEPTH_LIM;
    ld_in_range  = {1'b0, ld_addr_i} < DEPTH_LIM;
    req_ready_o  = rst_ni && !ld_we_i && !flush_i && (occ < 2'd2);
    accept       = req_valid_i && req_ready_o;
    rsp_hs       = rsp_valid_o && rsp_ready_i;
  end

  // Load-port write. Requests are stalled while loading, so the read
  // below never targets the word being written in the same cycle.
  always_ff @(posedge clk_i) begin
    if (ld_we_i && ld_in_range) begin
      mem[ld_addr_i[IDX_W-1:0]] <= ld_data_i;
    end
  end

  // Registered array read, enabled only on accept so it maps to block RAM.
  // An out-of-range address reads an arbitrary word that is masked below.
  always_ff @(posedge clk_i) begin
    if (accept) begin
      rd_word <= mem[req_addr_i[IDX_W-1:0]];
    end
  end

  // Control side of the read stage: a one-cycle "fresh data" strobe and the
  // range flag that travels with the word.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_valid <= 1'b0;
      rd_err   <= 1'b0;
    end else begin
      rd_valid <= accept;
      if (accept) begin
        rd_err <= !req_in_range;
      end
    end
  end

  // Replace whatever the array produced for a bad address with the filler
  // word so no undefined data ever reaches decode.
  always_comb begin
    rd_inst = rd_err ? NOP_INST : rd_word;
  end

  // Outstanding-response count: accepted but not yet handed to the
  // consumer. A handshake during a flush still counts as delivered, and the
  // flush then empties everything else.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      occ <= 2'd0;
    end else if (flush_i) begin
      occ <= 2'd0;
    end else if (accept && !rsp_hs) begin
      occ <= occ + 2'd1;
    end else if (!accept && rsp_hs) begin
      occ <= occ - 2'd1;
    end
  end

  imem_skid #(
    .DATA_W (DATA_W)
  ) u_skid (
    .clk       (clk_i),
    .rst_n     (rst_ni),
    .flush     (flush_i),
    .in_valid  (rd_valid),
    .in_inst   (rd_inst),
    .in_err    (rd_err),
    .out_valid (rsp_valid_o),
    .out_ready (rsp_ready_i),
    .out_inst  (rsp_inst_o),
    .out_err   (rsp_err_o)
  );

endmodule

// File: tb/tb_imem_sync.sv
// ---------------------------------------------------------------------------
// tb_imem_sync
// Drives imem_sync with directed scenarios followed by random traffic and
// compares every cycle against a reference made of a word array and a queue
// of expected responses.
// ---------------------------------------------------------------------------
module tb_imem_sync;

  localparam int          DATA_W = 32;
  localparam int          DEPTH  = 64;
  localparam int          ADDR_W = 8;
  localparam logic [31:0] NOP    = 32'h0000_0013;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        req_valid_i;
  logic        req_ready_o;
  logic [7:0]  req_addr_i;
  logic        rsp_valid_o;
  logic        rsp_ready_i;
  logic [31:0] rsp_inst_o;
  logic        rsp_err_o;
  logic        flush_i;
  logic        ld_we_i;
  logic [7:0]  ld_addr_i;
  logic [31:0] ld_data_i;

  int checks = 0;
  int errors = 0;

  logic [31:0] model_mem [DEPTH];
  logic [32:0] exp_q [$];

  always #5 clk_i = ~clk_i;

  imem_sync #(
    .DATA_W    (DATA_W),
    .DEPTH     (DEPTH),
    .ADDR_W    (ADDR_W),
    .INIT_FILE (""),
    .NOP_INST  (NOP)
  ) dut (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .req_valid_i (req_valid_i),
    .req_ready_o (req_ready_o),
    .req_addr_i  (req_addr_i),
    .rsp_valid_o (rsp_valid_o),
    .rsp_ready_i (rsp_ready_i),
    .rsp_inst_o  (rsp_inst_o),
    .rsp_err_o   (rsp_err_o),
    .flush_i     (flush_i),
    .ld_we_i     (ld_we_i),
    .ld_addr_i   (ld_addr_i),
    .ld_data_i   (ld_data_i)
  );

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // One clock cycle: drive inputs, check outputs mid-cycle against the
  // reference, then advance the reference to what the coming edge does.
  task automatic applyStimulus(input logic rv, input logic [7:0] ra, input logic rr,
                               input logic fl, input logic we, input logic [7:0] la,
                               input logic [31:0] ld);
    logic exp_ready;
    req_valid_i = rv;
    req_addr_i  = ra;
    rsp_ready_i = rr;
    flush_i     = fl;
    ld_we_i     = we;
    ld_addr_i   = la;
    ld_data_i   = ld;
    @(negedge clk_i);
    exp_ready = !we && !fl && (exp_q.size() < 2);
    checkOutput("req_ready", {31'b0, req_ready_o}, {31'b0, exp_ready});
    checkOutput("rsp_valid", {31'b0, rsp_valid_o}, {31'b0, exp_q.size() > 0});
    if (exp_q.size() > 0) begin
      checkOutput("rsp_inst", rsp_inst_o, exp_q[0][31:0]);
      checkOutput("rsp_err", {31'b0, rsp_err_o}, {31'b0, exp_q[0][32]});
    end
    if (exp_q.size() > 0 && rr) begin
      void'(exp_q.pop_front());
    end
    if (fl) begin
      exp_q.delete();
    end else if (rv && exp_ready) begin
      if (int'(ra) < DEPTH) exp_q.push_back({1'b0, model_mem[ra[5:0]]});
      else                  exp_q.push_back({1'b1, NOP});
    end
    if (we && int'(la) < DEPTH) begin
      model_mem[la[5:0]] = ld;
    end
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 8'd0, 1'b1, 1'b0, 1'b0, 8'd0, 32'd0);
  endtask

  // Asynchronous reset between clock edges; outputs must clear at once.
  task automatic doReset();
    req_valid_i = 1'b0;
    rsp_ready_i = 1'b0;
    flush_i     = 1'b0;
    ld_we_i     = 1'b0;
    rst_ni      = 1'b0;
    #1;
    checkOutput("reset_rsp_valid", {31'b0, rsp_valid_o}, 32'd0);
    checkOutput("reset_rsp_inst", rsp_inst_o, 32'd0);
    checkOutput("reset_rsp_err", {31'b0, rsp_err_o}, 32'd0);
    checkOutput("reset_req_ready", {31'b0, req_ready_o}, 32'd0);
    exp_q.delete();
    repeat (2) @(posedge clk_i);
    #1;
    rst_ni = 1'b1;
  endtask

  initial begin
    req_valid_i = 1'b0;
    req_addr_i  = 8'd0;
    rsp_ready_i = 1'b0;
    flush_i     = 1'b0;
    ld_we_i     = 1'b0;
    ld_addr_i   = 8'd0;
    ld_data_i   = 32'd0;
    rst_ni      = 1'b1;
    #2;
    doReset();

    // Download a program: word 5 is a known marker, the rest random.
    for (int i = 0; i < DEPTH; i++) begin
      applyStimulus(1'b0, 8'd0, 1'b1, 1'b0, 1'b1, 8'(i), (i == 5) ? 32'hDEAD_BEEF : $urandom);
    end

    // Single fetch with one-cycle latency.
    applyStimulus(1'b1, 8'd5, 1'b1, 1'b0, 1'b0, 8'd0, 32'd0);
    idle(2);

    // Back-to-back streaming of addresses 0..9.
    for (int i = 0; i < 10; i++) applyStimulus(1'b1, 8'(i), 1'b1, 1'b0, 1'b0, 8'd0, 32'd0);
    idle(2);

    // Backpressure: two accepts, then stall with outputs held.
    for (int i = 0; i < 5; i++) applyStimulus(1'b1, 8'(10 + i), 1'b0, 1'b0, 1'b0, 8'd0, 32'd0);
    idle(3);
    applyStimulus(1'b1, 8'd20, 1'b1, 1'b0, 1'b0, 8'd0, 32'd0);
    idle(2);

    // Out-of-range read, ignored out-of-range load, word 8 (alias of 200) untouched.
    applyStimulus(1'b1, 8'd200, 1'b1, 1'b0, 1'b0, 8'd0, 32'd0);
    applyStimulus(1'b0, 8'd0, 1'b1, 1'b0, 1'b1, 8'd200, 32'hBAD0_BAD0);
    applyStimulus(1'b1, 8'd200, 1'b1, 1'b0, 1'b0, 8'd0, 32'd0);
    applyStimulus(1'b1, 8'd8, 1'b1, 1'b0, 1'b0, 8'd0, 32'd0);
    applyStimulus(1'b1, 8'd64, 1'b1, 1'b0, 1'b0, 8'd0, 32'd0);
    idle(2);

    // Load then fetch the same word.
    applyStimulus(1'b1, 8'd3, 1'b1, 1'b0, 1'b1, 8'd3, 32'h1234_5678);
    applyStimulus(1'b1, 8'd3, 1'b1, 1'b0, 1'b0, 8'd0, 32'd0);
    idle(2);

    // Flush with two outstanding plus a new request.
    applyStimulus(1'b1, 8'd1, 1'b0, 1'b0, 1'b0, 8'd0, 32'd0);
    applyStimulus(1'b1, 8'd2, 1'b0, 1'b0, 1'b0, 8'd0, 32'd0);
    applyStimulus(1'b1, 8'd4, 1'b0, 1'b1, 1'b0, 8'd0, 32'd0);
    idle(2);

    // Reset in the middle of traffic, then confirm memory survived.
    applyStimulus(1'b1, 8'd6, 1'b0, 1'b0, 1'b0, 8'd0, 32'd0);
    applyStimulus(1'b1, 8'd7, 1'b0, 1'b0, 1'b0, 8'd0, 32'd0);
    doReset();
    idle(1);
    for (int i = 0; i < 10; i++) applyStimulus(1'b1, 8'(i), 1'b1, 1'b0, 1'b0, 8'd0, 32'd0);
    idle(2);

    // Random traffic mixing fetches, stalls, loads and flushes.
    for (int i = 0; i < 3000; i++) begin
      logic [7:0] ra;
      logic [7:0] la;
      ra = ($urandom_range(0, 9) == 0) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(0, 69));
      la = 8'($urandom_range(0, 69));
      applyStimulus($urandom_range(0, 9) < 7, ra, $urandom_range(0, 9) < 6,
                    $urandom_range(0, 19) == 0, $urandom_range(0, 9) == 0, la, $urandom);
    end
    idle(3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
